// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg : shared types and defaults for the PC fetch/execute sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_seq_pkg;

  localparam int unsigned ADDR_W_DEF      = 15;
  localparam int unsigned STACK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic {
    UPD_INC  = 1'b0,
    UPD_LOAD = 1'b1
  } upd_kind_e;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if : memory / datapath / PC-register signals of the sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              start;
  logic              halt_req;
  logic [ADDR_W-1:0] pc_value;
  logic              fetch_req;
  logic              mem_ready;
  logic              ir_valid;
  logic              exec_done;
  logic              branch_taken;
  logic              call_req;
  logic              ret_req;
  logic [ADDR_W-1:0] branch_target;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic              halted;
  logic              stack_err;

  // master is the sequencer itself; slave is the surrounding datapath/memory
  modport master (
    input  start, halt_req, pc_value, mem_ready, exec_done,
           branch_taken, call_req, ret_req, branch_target,
    output fetch_req, ir_valid, pc_load, pc_inc, pc_next, halted, stack_err
  );

  modport slave (
    output start, halt_req, pc_value, mem_ready, exec_done,
           branch_taken, call_req, ret_req, branch_target,
    input  fetch_req, ir_valid, pc_load, pc_inc, pc_next, halted, stack_err
  );

endinterface

`default_nettype wire

// File: rtl/ret_addr_stack.sv
// ---------------------------------------------------------------------------
// ret_addr_stack : LIFO of return addresses, pointer runs 0..DEPTH
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ret_addr_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              do_push, do_pop;
  logic [ADDR_W-1:0] entry_w [DEPTH];

  assign full_o  = (ptr_q == PTR_W'(DEPTH));
  assign empty_o = (ptr_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o & ~push_i;

  // Low pointer bits address the next free slot; one below it is the top
  assign wr_idx = ptr_q[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);
  assign data_o = entry_w[rd_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (do_push) begin
      ptr_d = ptr_q + PTR_W'(1);
    end else if (do_pop) begin
      ptr_d = ptr_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [ADDR_W-1:0] entry_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= '0;
      end else if (do_push && (wr_idx == IDX_W'(i))) begin
        entry_q <= data_i;
      end
    end

    assign entry_w[i] = entry_q;
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : fetch/decode/execute/update FSM driving PC load/inc strobes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_sequencer_if.master     bus
);

  state_e            state_q, state_d;
  upd_kind_e         kind_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;
  logic              fetch_req_q, ir_valid_q, pc_load_q, pc_inc_q, halted_q;
  logic              stack_err_q, stack_err_d;
  logic              push, pop;
  logic [ADDR_W-1:0] ret_addr, stk_top;
  logic              stk_full, stk_empty;

  assign ret_addr = bus.pc_value + ADDR_W'(1);

  ret_addr_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (ret_addr),
    .data_o  (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    state_d     = state_q;
    kind_d      = UPD_INC;
    pc_next_d   = pc_next_q;
    stack_err_d = stack_err_q;
    push        = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_FETCH;
      ST_FETCH:  if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (bus.exec_done) begin
          if (bus.halt_req) begin
            state_d = ST_HALT;
          end else if (bus.ret_req) begin
            if (stk_empty) begin
              stack_err_d = 1'b1;
              state_d     = ST_HALT;
            end else begin
              pop       = 1'b1;
              pc_next_d = stk_top;
              kind_d    = UPD_LOAD;
              state_d   = ST_UPDATE;
            end
          end else if (bus.call_req) begin
            // A call that cannot save its return address must not jump either
            if (stk_full) begin
              stack_err_d = 1'b1;
              state_d     = ST_HALT;
            end else begin
              push      = 1'b1;
              pc_next_d = bus.branch_target;
              kind_d    = UPD_LOAD;
              state_d   = ST_UPDATE;
            end
          end else if (bus.branch_taken) begin
            pc_next_d = bus.branch_target;
            kind_d    = UPD_LOAD;
            state_d   = ST_UPDATE;
          end else begin
            state_d = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_next_q   <= '0;
      fetch_req_q <= 1'b0;
      ir_valid_q  <= 1'b0;
      pc_load_q   <= 1'b0;
      pc_inc_q    <= 1'b0;
      halted_q    <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_next_q   <= pc_next_d;
      fetch_req_q <= (state_d == ST_FETCH);
      ir_valid_q  <= (state_d == ST_DECODE);
      pc_load_q   <= (state_d == ST_UPDATE) && (kind_d == UPD_LOAD);
      pc_inc_q    <= (state_d == ST_UPDATE) && (kind_d == UPD_INC);
      halted_q    <= (state_d == ST_HALT);
      stack_err_q <= stack_err_d;
    end
  end

  assign bus.fetch_req = fetch_req_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.pc_inc    = pc_inc_q;
  assign bus.pc_next   = pc_next_q;
  assign bus.halted    = halted_q;
  assign bus.stack_err = stack_err_q;

endmodule

`default_nettype wire
